// File: rtl/keypad_scan_decoder.sv
// keypad_scan_decoder: 4x4 keypad column scanner with debounced, single-shot key decode.
// Columns rotate on a divided scan tick; a single-key row hit is debounced before acceptance.
module keypad_scan_decoder #(
    parameter int SCAN_DIV       = 49_999,
    parameter int DEBOUNCE_SCANS = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);
    localparam int DW = $clog2(SCAN_DIV + 1);
    localparam logic [DW-1:0] DIV_END = DW'(SCAN_DIV);
    localparam logic [7:0] LAST = 8'(DEBOUNCE_SCANS - 1);
    // Nibble (row*4 + col) holds the code for that key position
    localparam logic [63:0] KEYMAP = 64'hDF0E_C987_B654_A321;

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

    state_t        state_q, state_d;
    logic [3:0]    row_m_q, row_s_q;
    logic [DW-1:0] div_q;
    logic          tick;
    logic [1:0]    k_q, k_d;
    logic [3:0]    row_lat_q, row_lat_d;
    logic [7:0]    match_q, match_d;
    logic [7:0]    rel_q, rel_d;
    logic [3:0]    code_q, code_d;
    logic          valid_q, valid_d;
    logic          held_q, held_d;
    logic          one_low;
    logic [1:0]    row_idx;
    logic [5:0]    map_sel;
    logic [3:0]    map_code;

    assign tick      = div_q == DIV_END;
    assign col       = ~(4'b0001 << k_q);
    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign key_held  = held_q;

    always_comb begin
        one_low  = (row_s_q == 4'b1110) || (row_s_q == 4'b1101) ||
                   (row_s_q == 4'b1011) || (row_s_q == 4'b0111);
        row_idx  = (row_lat_q == 4'b1110) ? 2'd0 :
                   (row_lat_q == 4'b1101) ? 2'd1 :
                   (row_lat_q == 4'b1011) ? 2'd2 : 2'd3;
        map_sel  = {row_idx, k_q, 2'b00};
        map_code = KEYMAP[map_sel +: 4];
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        row_lat_d = row_lat_q;
        match_d   = match_q;
        rel_d     = rel_q;
        code_d    = code_q;
        valid_d   = 1'b0;
        held_d    = held_q;
        if (tick) begin
            case (state_q)
                SCAN: begin
                    if (en && one_low) begin
                        row_lat_d = row_s_q;
                        match_d   = '0;
                        state_d   = DEBOUNCE;
                    end else begin
                        k_d = k_q + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (!en || row_s_q != row_lat_q) begin
                        state_d = SCAN;
                        k_d     = k_q + 2'd1;
                    end else if (match_q == LAST) begin
                        code_d  = map_code;
                        valid_d = 1'b1;
                        held_d  = 1'b1;
                        rel_d   = '0;
                        state_d = HELD;
                    end else begin
                        match_d = match_q + 8'd1;
                    end
                end
                HELD: begin
                    // en is deliberately ignored here so a held key always releases cleanly
                    if (row_s_q != 4'hF) begin
                        rel_d = '0;
                    end else if (rel_q == LAST) begin
                        held_d  = 1'b0;
                        state_d = SCAN;
                        k_d     = k_q + 2'd1;
                    end else begin
                        rel_d = rel_q + 8'd1;
                    end
                end
                default: state_d = SCAN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_m_q   <= '0;
            row_s_q   <= '0;
            div_q     <= '0;
            state_q   <= SCAN;
            k_q       <= '0;
            row_lat_q <= 4'hF;
            match_q   <= '0;
            rel_q     <= '0;
            code_q    <= '0;
            valid_q   <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            row_m_q   <= row;
            row_s_q   <= row_m_q;
            div_q     <= tick ? '0 : div_q + 1'b1;
            state_q   <= state_d;
            k_q       <= k_d;
            row_lat_q <= row_lat_d;
            match_q   <= match_d;
            rel_q     <= rel_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            held_q    <= held_d;
        end
    end
endmodule

// File: tb/tb_keypad_scan_decoder.sv
// tb_keypad_scan_decoder: keypad matrix model, tick-level reference model, vector table,
// directed corner sequences and randomized presses for keypad_scan_decoder.
module tb_keypad_scan_decoder;
    localparam int SCAN_DIV       = 3;
    localparam int DEBOUNCE_SCANS = 2;

    logic        clk, rst, en;
    logic [3:0]  row, col, key_code;
    logic        key_valid, key_held;
    logic [15:0] keys;

    int n_cmp  = 0;
    int n_fail = 0;
    int pulses = 0;

    keypad_scan_decoder #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DEBOUNCE_SCANS)) dut (
        .clk(clk), .rst(rst), .en(en), .row(row),
        .col(col), .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pressed key at (r,c) pulls row r low only while column c is driven low
    always_comb for (int r = 0; r < 4; r++) row[r] = ~|(keys[r*4 +: 4] & ~col);

    int         keymap [4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{14, 0, 15, 13}};
    logic [3:0] colseq [4]    = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    int         ph, m_k, m_mode, m_cnt, m_rel;
    logic [3:0] syncq [$];
    logic [3:0] m_lat, m_code;
    bit         m_valid, m_held, m_init;

    task automatic model_edge(input logic r_rst, input logic r_en, input logic [3:0] r_row);
        logic [3:0] rs;
        bit tk;
        int ri;
        m_valid = 1'b0;
        if (r_rst) begin
            ph = 0; syncq = '{4'h0, 4'h0};
            m_k = 0; m_mode = 0; m_cnt = 0; m_rel = 0;
            m_lat = 4'hF; m_code = 4'h0; m_held = 1'b0; m_init = 1'b1;
            return;
        end
        rs = syncq[0];
        tk = (ph == SCAN_DIV);
        ph = (ph + 1) % (SCAN_DIV + 1);
        void'(syncq.pop_front());
        syncq.push_back(r_row);
        if (!tk) return;
        if (m_mode == 0) begin
            if (r_en && $countones(~rs) == 1) begin
                m_lat = rs; m_cnt = 0; m_mode = 1;
            end else m_k = (m_k + 1) % 4;
        end else if (m_mode == 1) begin
            if (!r_en || rs != m_lat) begin
                m_mode = 0; m_k = (m_k + 1) % 4;
            end else begin
                m_cnt++;
                if (m_cnt == DEBOUNCE_SCANS) begin
                    ri = 0;
                    for (int i = 0; i < 4; i++) if (!m_lat[i]) ri = i;
                    m_code = 4'(keymap[ri][m_k]);
                    m_valid = 1'b1; m_held = 1'b1; m_rel = 0; m_mode = 2;
                end
            end
        end else begin
            if (rs == 4'hF) begin
                m_rel++;
                if (m_rel == DEBOUNCE_SCANS) begin
                    m_held = 1'b0; m_mode = 0; m_k = (m_k + 1) % 4;
                end
            end else m_rel = 0;
        end
    endtask

    always @(posedge clk) model_edge(rst, en, row);
    always @(posedge clk) if (key_valid === 1'b1) pulses++;

    always @(negedge clk) begin
        if (m_init) begin
            n_cmp++;
            if (col !== colseq[m_k] || key_code !== m_code || key_valid !== m_valid || key_held !== m_held) begin
                n_fail++;
                $display("FAIL model t=%0t: col/code/valid/held got %b/%h/%b/%b, expected %b/%h/%b/%b",
                         $time, col, key_code, key_valid, key_held, colseq[m_k], m_code, m_valid, m_held);
            end
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_valid(input int lim);
        for (int i = 0; i < lim && key_valid !== 1'b1; i++) @(negedge clk);
    endtask

    typedef struct {
        logic [15:0] keys;
        logic        en;
        int          hold;
        int          exp_pulses;
        logic [3:0]  exp_code;
    } vec_t;

    vec_t vecs [9];
    int   p0;

    initial begin
        vecs[0] = '{16'h0020, 1'b1, 40, 1, 4'h5};
        vecs[1] = '{16'h4000, 1'b1, 40, 1, 4'hF};
        vecs[2] = '{16'h2000, 1'b1, 40, 1, 4'h0};
        vecs[3] = '{16'h0008, 1'b1, 40, 1, 4'hA};
        vecs[4] = '{16'h1000, 1'b1, 40, 1, 4'hE};
        vecs[5] = '{16'h0800, 1'b1, 40, 1, 4'hC};
        vecs[6] = '{16'h0101, 1'b1, 40, 0, 4'hC};
        vecs[7] = '{16'h0040, 1'b0, 40, 0, 4'hC};
        vecs[8] = '{16'h0200, 1'b1, 40, 1, 4'h8};

        rst = 1'b1; en = 1'b1; keys = 16'h0;
        repeat (3) @(negedge clk);
        check("reset col", 16'(col), 16'hE);
        check("reset code", 16'(key_code), 16'h0);
        check("reset valid", 16'(key_valid), 16'h0);
        check("reset held", 16'(key_held), 16'h0);
        rst = 1'b0;
        for (int j = 0; j < 4; j++) begin
            repeat (4) @(negedge clk);
            check($sformatf("rotate step %0d", j), 16'(col), 16'(colseq[(j + 1) % 4]));
        end

        p0 = pulses;
        keys = 16'h0020;
        wait_valid(80);
        check("key5 valid", 16'(key_valid), 16'h1);
        check("key5 code", 16'(key_code), 16'h5);
        check("key5 col frozen", 16'(col), 16'b1101);
        check("key5 held", 16'(key_held), 16'h1);
        repeat (40) @(negedge clk);
        check("key5 single pulse", 16'(pulses - p0), 16'h1);
        check("key5 col still frozen", 16'(col), 16'b1101);
        keys = 16'h0;
        repeat (40) @(negedge clk);
        check("key5 released", 16'(key_held), 16'h0);
        check("key5 code kept", 16'(key_code), 16'h5);

        for (int i = 0; i < 40 && col == 4'b1011; i++) @(negedge clk);
        for (int i = 0; i < 40 && col != 4'b1011; i++) @(negedge clk);
        p0 = pulses;
        keys = 16'h0004;
        repeat (4) @(negedge clk);
        keys = 16'h0;
        repeat (4) @(negedge clk);
        check("bounce resumes col3", 16'(col), 16'b0111);
        repeat (20) @(negedge clk);
        check("bounce no pulse", 16'(pulses - p0), 16'h0);

        for (int i = 0; i < 9; i++) begin
            p0 = pulses;
            en = vecs[i].en;
            keys = vecs[i].keys;
            repeat (vecs[i].hold) @(negedge clk);
            check($sformatf("vec%0d held during", i), 16'(key_held), 16'(vecs[i].exp_pulses > 0));
            keys = 16'h0;
            en = 1'b1;
            repeat (40) @(negedge clk);
            check($sformatf("vec%0d pulses", i), 16'(pulses - p0), 16'(vecs[i].exp_pulses));
            check($sformatf("vec%0d code", i), 16'(key_code), 16'(vecs[i].exp_code));
            check($sformatf("vec%0d held after", i), 16'(key_held), 16'h0);
        end

        keys = 16'h0400;
        wait_valid(80);
        check("pre-reset valid", 16'(key_valid), 16'h1);
        repeat (6) @(negedge clk);
        check("pre-reset held", 16'(key_held), 16'h1);
        rst = 1'b1;
        keys = 16'h0;
        @(negedge clk);
        check("held reset col", 16'(col), 16'hE);
        check("held reset code", 16'(key_code), 16'h0);
        check("held reset valid", 16'(key_valid), 16'h0);
        check("held reset held", 16'(key_held), 16'h0);
        rst = 1'b0;
        p0 = pulses;
        repeat (60) @(negedge clk);
        check("no pulse after reset", 16'(pulses - p0), 16'h0);
        keys = 16'h0400;
        wait_valid(80);
        check("fresh press valid", 16'(key_valid), 16'h1);
        check("fresh press code", 16'(key_code), 16'h9);
        keys = 16'h0;
        repeat (40) @(negedge clk);

        for (int t = 0; t < 200; t++) begin
            int sel;
            sel = $urandom_range(0, 9);
            en = ($urandom_range(0, 9) != 0);
            rst = ($urandom_range(0, 49) == 0);
            keys = sel < 6 ? 16'(1 << $urandom_range(0, 15)) : sel < 8 ? 16'($urandom) : 16'h0;
            if (rst) begin
                @(negedge clk);
                rst = 1'b0;
            end
            repeat ($urandom_range(1, 50)) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
